// File: rtl/fb_arbiter_if.sv
// Draw-engine write port into the frame-buffer arbiter.
// master (draw engine) drives wr_valid/wr_addr/wr_data; slave (arbiter) drives wr_ready.
// A transfer completes in any cycle where wr_valid and wr_ready are both high.
interface fb_arbiter_if #(
   parameter int ADDR_W = 15,
   parameter int PIX_W  = 8
);
   logic              wr_valid;
   logic [ADDR_W-1:0] wr_addr;
   logic [PIX_W-1:0]  wr_data;
   logic              wr_ready;

   modport master (output wr_valid, output wr_addr, output wr_data, input wr_ready);
   modport slave  (input wr_valid, input wr_addr, input wr_data, output wr_ready);
endinterface

// File: rtl/fb_arbiter.sv
// Frame-buffer RAM owner: display fetch (fixed priority), clear engine, external writer.
// Latency: pix/hsync/vsync/blank_b are 2 cycles behind x/y/syncs; writes commit the cycle they are accepted.
// Backpressure: wr_ready drops on display slots, while a clear runs, and while reset_n is low.
// Ports: vgaclk/reset_n; x,y,hsync_in,vsync_in,blank_b_in from timing; wr (draw port);
//        clr_start/clr_color/clr_busy; ram_addr/ram_we/ram_wdata/ram_rdata; pix,hsync,vsync,blank_b to DAC.
module fb_arbiter #(
   parameter int SCALE   = 4,
   parameter int FB_W    = 160,
   parameter int FB_H    = 120,
   parameter int PIX_W   = 8,
   parameter int ADDR_W  = 15,
   parameter int HACTIVE = 640,
   parameter int VACTIVE = 480
) (
   input  logic              vgaclk,
   input  logic              reset_n,
   input  logic [9:0]        x,
   input  logic [9:0]        y,
   input  logic              hsync_in,
   input  logic              vsync_in,
   input  logic              blank_b_in,
   fb_arbiter_if.slave       wr,
   input  logic              clr_start,
   input  logic [PIX_W-1:0]  clr_color,
   output logic              clr_busy,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_we,
   output logic [PIX_W-1:0]  ram_wdata,
   input  logic [PIX_W-1:0]  ram_rdata,
   output logic [PIX_W-1:0]  pix,
   output logic              hsync,
   output logic              vsync,
   output logic              blank_b
);
   localparam int SH   = $clog2(SCALE);
   localparam int FB_N = FB_W * FB_H;
   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(FB_N - 1);

   typedef enum logic {IDLE, CLEAR} clr_state_t;

   clr_state_t        state;
   logic [ADDR_W-1:0] clr_cnt;
   logic [PIX_W-1:0]  clr_col;

   logic              slot;
   logic [9:0]        bx, by;
   logic [ADDR_W-1:0] disp_addr;
   logic              wr_in_range;

   // One cycle in SCALE is reserved for the display read while in the active area.
   assign slot = (x < 10'(HACTIVE)) && (y < 10'(VACTIVE)) && ((x & 10'(SCALE - 1)) == 10'd0);
   assign bx = x >> SH;
   assign by = y >> SH;
   assign disp_addr = ADDR_W'(32'(by) * 32'(FB_W) + 32'(bx));

   assign wr_in_range = 32'(wr.wr_addr) < 32'(FB_N);
   assign wr.wr_ready = ~slot & ~clr_busy & reset_n;

   always_comb begin
      ram_addr  = '0;
      ram_we    = 1'b0;
      ram_wdata = '0;
      if (slot) begin
         ram_addr = disp_addr;
      end else if (clr_busy) begin
         ram_addr  = clr_cnt;
         ram_we    = 1'b1;
         ram_wdata = clr_col;
      end else if (wr.wr_valid && wr.wr_ready) begin
         // Out-of-range addresses still handshake, but the write is dropped.
         ram_addr  = wr.wr_addr;
         ram_we    = wr_in_range;
         ram_wdata = wr.wr_data;
      end
   end

   // Clear engine: one write per non-slot cycle; clr_start is ignored while busy.
   always_ff @(posedge vgaclk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         clr_cnt  <= '0;
         clr_col  <= '0;
         clr_busy <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (clr_start) begin
                  state    <= CLEAR;
                  clr_cnt  <= '0;
                  clr_col  <= clr_color;
                  clr_busy <= 1'b1;
               end
            end
            CLEAR: begin
               if (!slot) begin
                  if (clr_cnt == LAST) begin
                     state    <= IDLE;
                     clr_cnt  <= '0;
                     clr_busy <= 1'b0;
                  end else begin
                     clr_cnt <= clr_cnt + 1'b1;
                  end
               end
            end
         endcase
      end
   end

   // Timing signals ride a 2-stage pipe to line up with the registered RAM read.
   logic             hs_d1, vs_d1, bl_d1, slot_d1;
   logic [PIX_W-1:0] pix_r;

   always_ff @(posedge vgaclk or negedge reset_n) begin
      if (!reset_n) begin
         hs_d1   <= 1'b1;
         vs_d1   <= 1'b1;
         bl_d1   <= 1'b0;
         hsync   <= 1'b1;
         vsync   <= 1'b1;
         blank_b <= 1'b0;
         slot_d1 <= 1'b0;
         pix_r   <= '0;
      end else begin
         hs_d1   <= hsync_in;
         vs_d1   <= vsync_in;
         bl_d1   <= blank_b_in;
         hsync   <= hs_d1;
         vsync   <= vs_d1;
         blank_b <= bl_d1;
         slot_d1 <= slot;
         // Capture only the fetched word so pix holds across the SCALE-wide pixel.
         if (slot_d1) pix_r <= ram_rdata;
      end
   end

   assign pix = blank_b ? pix_r : '0;
endmodule

// File: tb/tb_fb_arbiter.sv
// Bench for fb_arbiter: directed scenarios plus randomized traffic against a behavioural model.
module tb_fb_arbiter;
   logic       vgaclk;
   logic       reset_n;
   logic [9:0] x, y;
   logic       hsync_in, vsync_in, blank_b_in;
   logic       clr_start;
   logic [7:0] clr_color;
   logic       clr_busy;
   logic [14:0] ram_addr;
   logic       ram_we;
   logic [7:0] ram_wdata, ram_rdata;
   logic [7:0] pix;
   logic       hsync, vsync, blank_b;

   fb_arbiter_if #(.ADDR_W(15), .PIX_W(8)) wr_if ();

   fb_arbiter dut (
      .vgaclk(vgaclk), .reset_n(reset_n), .x(x), .y(y),
      .hsync_in(hsync_in), .vsync_in(vsync_in), .blank_b_in(blank_b_in),
      .wr(wr_if), .clr_start(clr_start), .clr_color(clr_color), .clr_busy(clr_busy),
      .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
      .pix(pix), .hsync(hsync), .vsync(vsync), .blank_b(blank_b)
   );

   initial vgaclk = 1'b0;
   always #5 vgaclk = ~vgaclk;

   // Synchronous single-port RAM, one-cycle read latency.
   logic [7:0] ram [0:32767];
   always @(posedge vgaclk) begin
      if (ram_we) ram[ram_addr] <= ram_wdata;
      ram_rdata <= ram[ram_addr];
   end

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef struct packed {
      logic       hs;
      logic       vs;
      logic       bl;
      logic [7:0] px;
   } tap_t;

   logic [7:0] mmem [0:19199];
   bit         m_busy;
   int         m_cnt;
   logic [7:0] m_col;
   logic [7:0] last_fetch;
   tap_t       hist[$];

   // One pixel clock: apply inputs at the falling edge, compare, then advance the model.
   task automatic step(input int xi, input int yi, input bit wv, input int wa, input int wd,
                       input bit cs, input int cc, input bit rn);
      bit slot, hs, vs, bl, rdy, e_we, inr, was_busy;
      int daddr, e_addr;
      logic [7:0] e_wd;
      tap_t t, rst_tap;
      rst_tap = '{hs: 1'b1, vs: 1'b1, bl: 1'b0, px: 8'h00};
      hs    = !(xi >= 656 && xi < 752);
      vs    = !(yi >= 490 && yi < 492);
      bl    = (xi < 640) && (yi < 480);
      slot  = bl && (xi % 4 == 0);
      daddr = (yi / 4) * 160 + xi / 4;
      inr   = wa < 19200;
      @(negedge vgaclk);
      x = 10'(xi); y = 10'(yi);
      hsync_in = hs; vsync_in = vs; blank_b_in = bl;
      wr_if.wr_valid = wv; wr_if.wr_addr = 15'(wa); wr_if.wr_data = 8'(wd);
      clr_start = cs; clr_color = 8'(cc); reset_n = rn;
      #1;
      if (!rn) begin
         m_busy = 0; m_cnt = 0; last_fetch = 8'h00;
         hist = {rst_tap, rst_tap};
      end
      rdy  = !slot && !m_busy && rn;
      e_wd = 8'h00;
      if (slot) begin e_we = 0; e_addr = daddr; end
      else if (m_busy) begin e_we = 1; e_addr = m_cnt; e_wd = m_col; end
      else if (wv && rdy) begin e_we = inr; e_addr = wa; e_wd = 8'(wd); end
      else begin e_we = 0; e_addr = 0; end
      chk("wr_ready", 32'(wr_if.wr_ready), 32'(rdy));
      chk("ram_we", 32'(ram_we), 32'(e_we));
      chk("ram_addr", 32'(ram_addr), 32'(e_addr));
      if (e_we) chk("ram_wdata", 32'(ram_wdata), 32'(e_wd));
      chk("clr_busy", 32'(clr_busy), 32'(m_busy));
      t = hist[0];
      chk("hsync", 32'(hsync), 32'(t.hs));
      chk("vsync", 32'(vsync), 32'(t.vs));
      chk("blank_b", 32'(blank_b), 32'(t.bl));
      chk("pix", 32'(pix), t.bl ? 32'(t.px) : 32'd0);
      if (rn) begin
         was_busy = m_busy;
         if (slot) last_fetch = mmem[daddr];
         t = hist.pop_front();
         hist.push_back('{hs: hs, vs: vs, bl: bl, px: last_fetch});
         if (m_busy && !slot) begin
            mmem[m_cnt] = m_col;
            if (m_cnt == 19199) begin m_busy = 0; m_cnt = 0; end
            else m_cnt++;
         end else if (wv && rdy && inr) begin
            mmem[wa] = 8'(wd);
         end
         if (!was_busy && cs) begin m_busy = 1; m_cnt = 0; m_col = 8'(cc); end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int writes, n;
      bit done;
      logic [7:0] pexp [0:15];
      for (int i = 0; i < 32768; i++) ram[i] = 8'h00;
      for (int i = 0; i < 19200; i++) mmem[i] = 8'h00;
      m_busy = 0; m_cnt = 0; m_col = 8'h00; last_fetch = 8'h00;
      hist = {};
      hist.push_back('{hs: 1'b1, vs: 1'b1, bl: 1'b0, px: 8'h00});
      hist.push_back('{hs: 1'b1, vs: 1'b1, bl: 1'b0, px: 8'h00});
      reset_n = 1'b1; x = '0; y = '0; hsync_in = 1'b1; vsync_in = 1'b1; blank_b_in = 1'b0;
      wr_if.wr_valid = 1'b0; wr_if.wr_addr = '0; wr_if.wr_data = '0;
      clr_start = 1'b0; clr_color = '0;

      // Reset held with a pending write request.
      for (int i = 0; i < 3; i++) begin
         step(0, 0, 1, 7, 8'h99, 0, 0, 0);
         chk("rst_wr_ready", 32'(wr_if.wr_ready), 32'd0);
         chk("rst_ram_we", 32'(ram_we), 32'd0);
         chk("rst_pix", 32'(pix), 32'd0);
         chk("rst_hsync", 32'(hsync), 32'd1);
         chk("rst_vsync", 32'(vsync), 32'd1);
         chk("rst_blank_b", 32'(blank_b), 32'd0);
         chk("rst_clr_busy", 32'(clr_busy), 32'd0);
      end
      step(0, 0, 0, 0, 0, 0, 0, 1);
      chk("first_slot_addr", 32'(ram_addr), 32'd0);
      chk("first_slot_we", 32'(ram_we), 32'd0);

      // Preload 160..162 in blanking, then fetch them through a scan line.
      step(700, 500, 1, 160, 8'h11, 0, 0, 1);
      chk("preload_ready", 32'(wr_if.wr_ready), 32'd1);
      step(700, 500, 1, 161, 8'hA5, 0, 0, 1);
      chk("preload_we", 32'(ram_we), 32'd1);
      step(700, 500, 1, 162, 8'h22, 0, 0, 1);
      step(700, 500, 0, 0, 0, 0, 0, 1);
      step(700, 500, 0, 0, 0, 0, 0, 1);
      for (int k = 0; k < 16; k++) pexp[k] = 8'h00;
      for (int k = 2; k < 6; k++) pexp[k] = 8'h11;
      for (int k = 6; k < 10; k++) pexp[k] = 8'hA5;
      for (int k = 10; k < 14; k++) pexp[k] = 8'h22;
      for (int k = 0; k < 14; k++) begin
         step(k, 4, 0, 0, 0, 0, 0, 1);
         if (k == 4) begin
            chk("slot_addr_161", 32'(ram_addr), 32'd161);
            chk("slot_we", 32'(ram_we), 32'd0);
         end
         chk("scan_pix", 32'(pix), 32'(pexp[k]));
         chk("scan_blank_b", 32'(blank_b), (k < 2) ? 32'd0 : 32'd1);
         chk("scan_hsync", 32'(hsync), (k < 2) ? 32'd0 : 32'd1);
      end

      // Writes during active video are refused only on slot cycles.
      for (int k = 0; k < 8; k++) begin
         step(k, 8, 1, 5, 8'h3C, 0, 0, 1);
         chk("active_wr_ready", 32'(wr_if.wr_ready), (k % 4 != 0) ? 32'd1 : 32'd0);
         if (k % 4 != 0) begin
            chk("active_we", 32'(ram_we), 32'd1);
            chk("active_addr", 32'(ram_addr), 32'd5);
         end
      end

      // Out-of-range address: handshake completes, write is dropped.
      step(700, 500, 1, 19200, 8'h77, 0, 0, 1);
      chk("oor_ready", 32'(wr_if.wr_ready), 32'd1);
      chk("oor_we", 32'(ram_we), 32'd0);

      // Full clear in vertical blanking, with a second clr_start mid-way.
      step(0, 500, 0, 0, 0, 1, 8'h1F, 1);
      writes = 0; done = 0; n = 0;
      while (!done && n < 25000) begin
         step(n % 800, 500, 1, int'($urandom_range(0, 19199)), int'($urandom_range(0, 255)),
              n == 5000, 8'hE0, 1);
         if (n == 0) chk("clr_busy_rise", 32'(clr_busy), 32'd1);
         if (clr_busy !== 1'b1) begin
            done = 1;
         end else begin
            chk("clr_wr_ready", 32'(wr_if.wr_ready), 32'd0);
            if (ram_we) begin
               chk("clr_seq_addr", 32'(ram_addr), 32'(writes));
               chk("clr_color", 32'(ram_wdata), 32'h1F);
               writes++;
            end
         end
         n++;
      end
      chk("clr_finished", 32'(done), 32'd1);
      chk("clr_total_writes", 32'(writes), 32'd19200);
      chk("clr_ram_first", 32'(ram[0]), 32'h1F);
      chk("clr_ram_last", 32'(ram[19199]), 32'h1F);

      // Reset in the middle of a clear.
      step(0, 500, 0, 0, 0, 1, 8'h2A, 1);
      writes = 0; n = 0;
      while (writes < 100 && n < 500) begin
         step(n % 800, 500, 0, 0, 0, 0, 0, 1);
         if (clr_busy && ram_we) writes++;
         n++;
      end
      chk("midclr_reached", 32'(writes), 32'd100);
      step(0, 500, 0, 0, 0, 0, 0, 0);
      chk("midclr_busy_drop", 32'(clr_busy), 32'd0);
      chk("midclr_we", 32'(ram_we), 32'd0);
      step(0, 500, 0, 0, 0, 0, 0, 0);
      for (int k = 0; k < 8; k++) begin
         step(k, 0, 1, 3, 8'h44, 0, 0, 1);
         chk("post_rst_ready", 32'(wr_if.wr_ready), (k % 4 != 0) ? 32'd1 : 32'd0);
         chk("post_rst_busy", 32'(clr_busy), 32'd0);
      end
      chk("partial_99", 32'(ram[99]), 32'h2A);
      chk("partial_100", 32'(ram[100]), 32'h1F);

      // Randomized traffic against the model.
      for (int i = 0; i < 15000; i++) begin
         int rx, ry, ra;
         rx = int'($urandom_range(0, 799));
         ry = ($urandom_range(0, 3) == 0) ? int'($urandom_range(480, 524)) : int'($urandom_range(0, 479));
         ra = ($urandom_range(0, 15) == 0) ? int'($urandom_range(19200, 32767)) : int'($urandom_range(0, 19199));
         step(rx, ry, $urandom_range(0, 1) == 1, ra, int'($urandom_range(0, 255)),
              $urandom_range(0, 2999) == 0, int'($urandom_range(0, 255)),
              $urandom_range(0, 3999) != 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
